mux4_share_arbiter: RTL and testbench
=====================================

Name: mux4_share_arbiter

Overview:
- Shares one 74S153-style dual 4:1 data selector among four requesters.
- Arbitrates round-robin and drives the selector's SEL1/SEL0 and active-low strobe.
- Holds the strobe off across every select change for a programmable settle interval, so the shared output never glitches between owners.
- Sits beside the selector on the shared-source path; requesters see a req/gnt handshake only.

Parameters:
- SETTLE_CYCLES, 1, cycles the strobe stays high after a select change before grant (0..15; 0 = grant on the same edge as the select update).
- HOLD_MAX, 8, maximum consecutive grant cycles per owner (1..255; 0 = unlimited).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester; level; held until gnt is seen and for as long as the bus is needed.
- gnt  out  4  one-hot grant, or all zero.
- sel  out  2  select to the mux; sel[1] drives SEL1, sel[0] drives SEL0.
- enb_n  out  1  active-low strobe to the mux (both halves, ENB1_N/ENB2_N).
- busy  out  1  high whenever the state is not IDLE.
- owner  out  2  index of the last requester that completed a grant (round-robin pointer).

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - state = IDLE, sel = 0, enb_n = 1, gnt = 0, busy = 0.
  - owner = 3, so requester 0 has top priority first.
  - Settle and hold counters = 0.
- All outputs are registered.
- Invariants:
  - enb_n == ~|gnt at all times.
  - gnt is one-hot or zero.
  - When gnt[i] = 1, sel == i.
- States: IDLE, SETTLE, GRANT.
- IDLE:
  - If req == 0, stay.
  - Otherwise pick the first set bit scanning owner+1, owner+2, owner+3, owner (mod 4).
  - At that edge, sel <= pick.
  - If SETTLE_CYCLES > 0: go to SETTLE with cnt <= SETTLE_CYCLES; enb_n stays 1.
  - If SETTLE_CYCLES = 0: go directly to GRANT with gnt[pick] <= 1, enb_n <= 0, hold <= 1.
- SETTLE:
  - If req[sel] drops: abort to IDLE. gnt stays 0, owner is unchanged, and sel keeps its value.
  - Else if cnt == 1: go to GRANT, set gnt[sel] and enb_n = 0, hold <= 1.
  - Else cnt <= cnt - 1.
- Latency: req sampled at edge E in IDLE; gnt is visible after edge E + SETTLE_CYCLES (same edge E when SETTLE_CYCLES = 0).
- GRANT:
  - Release condition: req[sel] low, or HOLD_MAX != 0 and hold == HOLD_MAX.
  - On release: gnt <= 0, enb_n <= 1, owner <= sel, go to IDLE. This gives at least one dead cycle (break-before-make).
  - Otherwise hold <= hold + 1, saturating at 255.
- A requester preempted by hold expiry that still requests is lowest priority next round.
- If the preempted requester is the only requester, it is re-granted after the dead cycle plus settle. The select does not change in that case, but settle is still applied.
- Requests arriving on other lines during SETTLE or GRANT are ignored until IDLE.
- busy = (state != IDLE).
- Counter widths: cnt is 4 bits, hold is 8 bits. All index arithmetic wraps mod 4.

Decomposition:
- Package mux4_arb_pkg:
  - state enum {IDLE, SETTLE, GRANT}.
  - NUM_REQ = 4, IDX_W = 2, CNT_W = 4, HOLD_W = 8.
- Sub-module rr_pick4: combinational round-robin picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: valid, idx[1:0].
  - Instantiated once; separately unit-testable.

Test Plan:
- Reset, then req = 0001 with SETTLE_CYCLES = 1 → sel = 0 after edge 1, gnt = 0001/enb_n = 0 after edge 2. Drop req → gnt = 0, enb_n = 1, owner = 0 next edge.
- req = 1111 held, HOLD_MAX = 8 → grants in order 0, 1, 2, 3, 0, each exactly 8 cycles. Between owners: enb_n = 1 for 1 + SETTLE_CYCLES cycles; sel changes only while enb_n = 1.
- Owner 1, req = 0101 → next grant goes to 2; after that, to 0 (wrap). owner tracks 1 → 2 → 0.
- req[3] asserted, then dropped during SETTLE (SETTLE_CYCLES = 3) → no gnt pulse, state IDLE, owner unchanged. A later req = 1000 is granted normally.
- reset_n pulsed low mid-GRANT (no clock edge) → gnt = 0, enb_n = 1, sel = 0, owner = 3 immediately; after release, req = 1111 grants requester 0 first.
- SETTLE_CYCLES = 0, HOLD_MAX = 0, single req = 0010 held 100 cycles → gnt = 0010 one edge after req, never released. Check invariant enb_n == ~|gnt every cycle.

Source files
------------

// File: rtl/mux4_share_arbiter_pkg.sv
// rtl/mux4_share_arbiter_pkg.sv - shared types and sizes for the mux4 share arbiter
package mux4_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int CNT_W   = 4;
   localparam int HOLD_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GRANT  = 2'd2
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux4_share_arbiter_if.sv
// rtl/mux4_share_arbiter_if.sv - requester handshake and selector control bundle
interface mux4_share_arbiter_if;
   import mux4_arb_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   sel;
   logic               enb_n;
   logic               busy;
   logic [IDX_W-1:0]   owner;

   // master: the arbiter; slave: requesters plus the selector it steers
   modport master (input req, output gnt, sel, enb_n, busy, owner);
   modport slave  (output req, input gnt, sel, enb_n, busy, owner);

endinterface

// File: rtl/mux4_share_arbiter_rr_pick4.sv
// rtl/mux4_share_arbiter_rr_pick4.sv - combinational round-robin picker for four requesters
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   // Scan from lowest priority (last) up to highest (last+1) so the highest hit wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = last_i;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_i[last_i + IDX_W'(k)]) begin
            valid_o = 1'b1;
            idx_o   = last_i + IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/mux4_share_arbiter.sv
// rtl/mux4_share_arbiter.sv - round-robin owner of a shared 74S153-style dual 4:1 selector
module mux4_share_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int HOLD_MAX      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   mux4_share_arbiter_if.master bus
);

   arb_state_e         state_q;
   logic [IDX_W-1:0]   sel_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic               enb_n_q;
   logic               busy_q;
   logic [IDX_W-1:0]   owner_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [HOLD_W-1:0]  hold_q;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic               release_now;

   rr_pick4 u_pick (
      .req_i   (bus.req),
      .last_i  (owner_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign release_now = !bus.req[sel_q] ||
                        ((HOLD_MAX != 0) && (hold_q == HOLD_W'(HOLD_MAX)));

   // gnt and enb_n always change on the same edge, keeping enb_n == ~|gnt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         gnt_q   <= '0;
         enb_n_q <= 1'b1;
         busy_q  <= 1'b0;
         owner_q <= IDX_W'(NUM_REQ - 1);
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  sel_q  <= pick_idx;
                  busy_q <= 1'b1;
                  if (SETTLE_CYCLES == 0) begin
                     state_q <= GRANT;
                     gnt_q   <= idx2onehot(pick_idx);
                     enb_n_q <= 1'b0;
                     hold_q  <= HOLD_W'(1);
                  end else begin
                     state_q <= SETTLE;
                     cnt_q   <= CNT_W'(SETTLE_CYCLES);
                  end
               end
            end
            SETTLE: begin
               if (!bus.req[sel_q]) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_W'(1)) begin
                  state_q <= GRANT;
                  gnt_q   <= idx2onehot(sel_q);
                  enb_n_q <= 1'b0;
                  hold_q  <= HOLD_W'(1);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            GRANT: begin
               if (release_now) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  gnt_q   <= '0;
                  enb_n_q <= 1'b1;
                  owner_q <= sel_q;
               end else if (hold_q != '1) begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               gnt_q   <= '0;
               enb_n_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.sel   = sel_q;
   assign bus.enb_n = enb_n_q;
   assign bus.busy  = busy_q;
   assign bus.owner = owner_q;

endmodule

// File: tb/tb_mux4_share_arbiter.sv
// tb/tb_mux4_share_arbiter.sv - self-checking bench for mux4_share_arbiter
module tb_mux4_share_arbiter;
   import mux4_arb_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_q[$];
   bit   sb_en    = 1'b0;
   logic [3:0] sb_prev = 4'd0;

   mux4_share_arbiter_if if_a ();
   mux4_share_arbiter_if if_b ();
   mux4_share_arbiter_if if_c ();

   mux4_share_arbiter #(.SETTLE_CYCLES(1), .HOLD_MAX(8)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a.master));
   mux4_share_arbiter #(.SETTLE_CYCLES(3), .HOLD_MAX(8)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b.master));
   mux4_share_arbiter #(.SETTLE_CYCLES(0), .HOLD_MAX(0)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c.master));

   always #5 clk = ~clk;

   // Scoreboard: each new grant on u_a must match the next queued owner index.
   always @(negedge clk) begin : sb_mon
      int e;
      if (sb_en && (if_a.gnt != 4'd0) && (sb_prev == 4'd0)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_grant: got gnt=%b, required no grant", if_a.gnt);
         end else begin
            e = exp_q.pop_front();
            if (if_a.gnt !== 4'(1 << e)) begin
               n_fail++;
               $display("FAIL sb_grant_order: got gnt=%b, required %b", if_a.gnt, 4'(1 << e));
            end
         end
      end
      sb_prev = if_a.gnt;
   end

   task automatic do_reset();
      reset_n   = 1'b0;
      if_a.req  = '0;
      if_b.req  = '0;
      if_c.req  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_gnt_a(input bit want_on, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((if_a.gnt != 4'd0) == want_on) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      if_a.req = '0; if_b.req = '0; if_c.req = '0;
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({if_a.gnt, if_a.sel, if_a.enb_n, if_a.busy, if_a.owner} !== {4'd0, 2'd0, 1'b1, 1'b0, 2'd3}) begin
         n_fail++;
         $display("FAIL reset_a: got gnt=%b sel=%0d enb_n=%b busy=%b owner=%0d, required 0000/0/1/0/3",
                  if_a.gnt, if_a.sel, if_a.enb_n, if_a.busy, if_a.owner);
      end
      n_checks++;
      if ({if_b.gnt, if_b.enb_n, if_b.owner, if_c.gnt, if_c.enb_n, if_c.owner} !== {4'd0, 1'b1, 2'd3, 4'd0, 1'b1, 2'd3}) begin
         n_fail++;
         $display("FAIL reset_bc: got b gnt=%b enb_n=%b owner=%0d c gnt=%b enb_n=%b owner=%0d, required 0000/1/3",
                  if_b.gnt, if_b.enb_n, if_b.owner, if_c.gnt, if_c.enb_n, if_c.owner);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (if_a.busy !== 1'b0 || if_a.gnt !== 4'd0) begin
         n_fail++;
         $display("FAIL idle_no_req: got busy=%b gnt=%b, required 0/0000", if_a.busy, if_a.gnt);
      end
   endtask

   task automatic test_single_grant();
      sb_en = 1'b1;
      exp_q.push_back(0);
      if_a.req = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (if_a.sel !== 2'd0 || if_a.gnt !== 4'd0 || if_a.enb_n !== 1'b1 || if_a.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_edge1: got sel=%0d gnt=%b enb_n=%b busy=%b, required 0/0000/1/1",
                  if_a.sel, if_a.gnt, if_a.enb_n, if_a.busy);
      end
      @(negedge clk);
      n_checks++;
      if (if_a.gnt !== 4'b0001 || if_a.enb_n !== 1'b0) begin
         n_fail++;
         $display("FAIL single_edge2: got gnt=%b enb_n=%b, required 0001/0", if_a.gnt, if_a.enb_n);
      end
      if_a.req = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (if_a.gnt !== 4'd0 || if_a.enb_n !== 1'b1 || if_a.owner !== 2'd0 || if_a.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: got gnt=%b enb_n=%b owner=%0d busy=%b, required 0000/1/0/0",
                  if_a.gnt, if_a.enb_n, if_a.owner, if_a.busy);
      end
   endtask

   task automatic test_round_robin();
      int run_len = 0;
      int gap = 0;
      int n_done = 0;
      int cyc = 0;
      logic [3:0] pg;
      logic [1:0] ps;
      do_reset();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(0);
      pg = if_a.gnt;
      ps = if_a.sel;
      if_a.req = 4'b1111;
      while (n_done < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (if_a.sel != ps) begin
            n_checks++;
            if (if_a.enb_n !== 1'b1) begin
               n_fail++;
               $display("FAIL rr_sel_change_enabled: got enb_n=%b at sel change, required 1", if_a.enb_n);
            end
         end
         if (if_a.gnt != 4'd0) begin
            if (pg == 4'd0 && n_done > 0) begin
               n_checks++;
               if (gap != 2) begin
                  n_fail++;
                  $display("FAIL rr_dead_gap: got %0d strobe-off cycles, required 2", gap);
               end
            end
            run_len++;
         end else begin
            if (pg != 4'd0) begin
               n_checks++;
               if (run_len != 8) begin
                  n_fail++;
                  $display("FAIL rr_hold_len: got %0d grant cycles, required 8", run_len);
               end
               n_done++;
               run_len = 0;
               gap = 0;
            end
            gap++;
         end
         pg = if_a.gnt;
         ps = if_a.sel;
      end
      if_a.req = 4'b0000;
      n_checks++;
      if (n_done != 5) begin
         n_fail++;
         $display("FAIL rr_timeout: got %0d completed grants, required 5", n_done);
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (if_a.owner !== 2'd0 || if_a.busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rr_end: got owner=%0d busy=%b pending=%0d, required 0/0/0",
                  if_a.owner, if_a.busy, exp_q.size());
      end
   endtask

   task automatic test_rr_wrap();
      bit ok;
      exp_q.push_back(1);
      if_a.req = 4'b0010;
      wait_gnt_a(1'b1, ok);
      if_a.req = 4'b0000;
      wait_gnt_a(1'b0, ok);
      @(negedge clk);
      n_checks++;
      if (if_a.owner !== 2'd1) begin
         n_fail++;
         $display("FAIL wrap_owner1: got owner=%0d, required 1", if_a.owner);
      end
      exp_q.push_back(2); exp_q.push_back(0);
      if_a.req = 4'b0101;
      wait_gnt_a(1'b1, ok);
      n_checks++;
      if (!ok || if_a.gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL wrap_pick2: got gnt=%b ok=%b, required 0100", if_a.gnt, ok);
      end
      wait_gnt_a(1'b0, ok);
      n_checks++;
      if (!ok || if_a.owner !== 2'd2) begin
         n_fail++;
         $display("FAIL wrap_owner2: got owner=%0d ok=%b, required 2", if_a.owner, ok);
      end
      wait_gnt_a(1'b1, ok);
      n_checks++;
      if (!ok || if_a.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL wrap_pick0: got gnt=%b ok=%b, required 0001", if_a.gnt, ok);
      end
      if_a.req = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (if_a.owner !== 2'd0 || if_a.gnt !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_owner0: got owner=%0d gnt=%b, required 0/0000", if_a.owner, if_a.gnt);
      end
   endtask

   task automatic test_settle_abort();
      if_b.req = 4'b1000;
      @(negedge clk);
      n_checks++;
      if (if_b.busy !== 1'b1 || if_b.sel !== 2'd3 || if_b.gnt !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_settle: got busy=%b sel=%0d gnt=%b, required 1/3/0000", if_b.busy, if_b.sel, if_b.gnt);
      end
      @(negedge clk);
      if_b.req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (if_b.gnt !== 4'd0 || if_b.enb_n !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_pulse: got gnt=%b enb_n=%b, required 0000/1", if_b.gnt, if_b.enb_n);
         end
      end
      n_checks++;
      if (if_b.busy !== 1'b0 || if_b.owner !== 2'd3 || if_b.sel !== 2'd3) begin
         n_fail++;
         $display("FAIL abort_state: got busy=%b owner=%0d sel=%0d, required 0/3/3", if_b.busy, if_b.owner, if_b.sel);
      end
      if_b.req = 4'b1000;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (if_b.gnt !== ((i == 4) ? 4'b1000 : 4'b0000)) begin
            n_fail++;
            $display("FAIL settle3_latency: got gnt=%b after %0d edges, required %b",
                     if_b.gnt, i, (i == 4) ? 4'b1000 : 4'b0000);
         end
      end
      if_b.req = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (if_b.busy !== 1'b0 || if_b.owner !== 2'd3 || if_b.enb_n !== 1'b1) begin
         n_fail++;
         $display("FAIL settle3_release: got busy=%b owner=%0d enb_n=%b, required 0/3/1", if_b.busy, if_b.owner, if_b.enb_n);
      end
   endtask

   task automatic test_reset_mid_grant();
      bit ok;
      exp_q.push_back(2);
      if_a.req = 4'b0100;
      wait_gnt_a(1'b1, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL midrst_setup: got no grant, required gnt=0100");
      end
      #1;
      reset_n = 1'b0;
      if_a.req = 4'b0000;
      #1;
      n_checks++;
      if ({if_a.gnt, if_a.enb_n, if_a.sel, if_a.owner, if_a.busy} !== {4'd0, 1'b1, 2'd0, 2'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_async: got gnt=%b enb_n=%b sel=%0d owner=%0d busy=%b, required 0000/1/0/3/0",
                  if_a.gnt, if_a.enb_n, if_a.sel, if_a.owner, if_a.busy);
      end
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      exp_q.push_back(0);
      if_a.req = 4'b1111;
      wait_gnt_a(1'b1, ok);
      n_checks++;
      if (!ok || if_a.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL midrst_first: got gnt=%b ok=%b, required 0001", if_a.gnt, ok);
      end
      if_a.req = 4'b0000;
      wait_gnt_a(1'b0, ok);
   endtask

   task automatic test_hold_unlimited();
      if_c.req = 4'b0010;
      @(negedge clk);
      n_checks++;
      if (if_c.gnt !== 4'b0010 || if_c.enb_n !== 1'b0 || if_c.sel !== 2'd1 || if_c.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL nosettle_latency: got gnt=%b enb_n=%b sel=%0d busy=%b, required 0010/0/1/1",
                  if_c.gnt, if_c.enb_n, if_c.sel, if_c.busy);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_checks++;
         if (if_c.gnt !== 4'b0010 || if_c.enb_n !== ~|if_c.gnt) begin
            n_fail++;
            $display("FAIL unlimited_hold: got gnt=%b enb_n=%b at cycle %0d, required 0010/0", if_c.gnt, if_c.enb_n, i);
         end
      end
      if_c.req = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (if_c.gnt !== 4'd0 || if_c.enb_n !== 1'b1 || if_c.owner !== 2'd1) begin
         n_fail++;
         $display("FAIL unlimited_release: got gnt=%b enb_n=%b owner=%0d, required 0000/1/1",
                  if_c.gnt, if_c.enb_n, if_c.owner);
      end
   endtask

   initial begin
      if_a.req = '0; if_b.req = '0; if_c.req = '0;
      test_reset();
      test_single_grant();
      test_round_robin();
      test_rr_wrap();
      test_settle_abort();
      test_reset_mid_grant();
      test_hold_unlimited();
      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending grants, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
